// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, 1-cycle imem reads, small output FIFO to decode.
// Redirects flush the FIFO and bump an epoch so in-flight wrong-path data is dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic          req_epoch;
    logic          epoch;
    logic          misalign_q;

    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic          redirect_eff;
    logic [31:0]   target;
    logic          pop;
    logic          push;
    logic          issue;
    logic [PW+1:0] occupancy;

    assign redirect_eff = redirect_valid && (redirect_sel == 2'b01 || redirect_sel == 2'b10);
    assign target       = (redirect_sel == 2'b10) ? (jalr_target & ~32'h1) : branch_target;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight && (req_epoch == epoch) && !redirect_eff;

    // Slots already committed (buffered + in flight) after this cycle's pop; pop implies count>=1.
    assign occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, inflight} - {{(PW + 1){1'b0}}, pop};
    assign issue     = rst_n && !redirect_eff && (occupancy < (PW + 2)'(FIFO_DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign misalign  = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            req_pc     <= '0;
            inflight   <= 1'b0;
            req_epoch  <= 1'b0;
            epoch      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            inflight   <= issue;
            misalign_q <= redirect_eff && (target[1:0] != 2'b00);
            if (redirect_eff) begin
                pc    <= {target[31:2], 2'b00};
                epoch <= ~epoch;
            end else if (issue) begin
                pc        <= pc + 32'd4;
                req_pc    <= pc;
                req_epoch <= epoch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect_eff) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= req_pc;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based stream model checked every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, out_valid, out_ready, misalign;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic        redirect_valid;
    logic [1:0]  redirect_sel;
    logic [31:0] branch_target, jalr_target;

    logic        imem_req2, out_valid2, misalign2;
    logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2;
    logic        tie0 = 1'b0;
    logic        tie1 = 1'b1;
    logic [1:0]  tie_sel = 2'b00;
    logic [31:0] tie_w = 32'h0;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .branch_target(branch_target), .jalr_target(jalr_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(RPC2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_valid(tie0), .redirect_sel(tie_sel),
        .branch_target(tie_w), .jalr_target(tie_w), .out_valid(out_valid2),
        .out_ready(tie1), .out_instr(out_instr2), .out_pc(out_pc2), .misalign(misalign2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memories: data appears the cycle after a request.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= memf(imem_addr);
        if (imem_req2) imem_rdata2 <= memf(imem_addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stream model: queue of buffered PCs, one pending response, current fetch PC.
    logic [31:0] q_pc[$];
    logic [31:0] m_pc      = RPC;
    bit          m_pend    = 0;
    logic [31:0] m_pend_pc = '0;
    bit          m_mis     = 0;

    function automatic bit m_eff();
        return redirect_valid && (redirect_sel == 2'b01 || redirect_sel == 2'b10);
    endfunction

    function automatic logic [31:0] m_tgt();
        return (redirect_sel == 2'b10) ? (jalr_target & ~32'h1) : branch_target;
    endfunction

    function automatic bit m_pop();
        return (q_pc.size() > 0) && out_ready;
    endfunction

    function automatic bit m_issue();
        int occ;
        occ = q_pc.size() + int'(m_pend) - int'(m_pop());
        return rst_n && !m_eff() && (occ < 2);
    endfunction

    bit          s_eff, s_pop, s_iss;
    logic [31:0] s_tgt, s_old;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc.delete();
            m_pc   = RPC;
            m_pend = 0;
            m_mis  = 0;
        end else begin
            s_eff = m_eff();
            s_pop = m_pop();
            s_iss = m_issue();
            s_tgt = m_tgt();
            s_old = m_pc;
            m_mis = s_eff && (s_tgt[1:0] != 2'b00);
            if (s_eff) begin
                q_pc.delete();
            end else begin
                if (s_pop) void'(q_pc.pop_front());
                if (m_pend) q_pc.push_back(m_pend_pc);
            end
            if (s_eff)      m_pc = {s_tgt[31:2], 2'b00};
            else if (s_iss) m_pc = m_pc + 32'd4;
            m_pend    = s_iss;
            m_pend_pc = s_old;
        end
    end

    always @(negedge clk) begin
        chk("m_req", imem_req, m_issue());
        chk("m_addr", imem_addr, m_pc);
        chk("m_valid", out_valid, (q_pc.size() > 0));
        chk("m_mis", misalign, m_mis);
        if (q_pc.size() > 0) begin
            chk("m_pc", out_pc, q_pc[0]);
            chk("m_instr", out_instr, memf(q_pc[0]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] jt);
        redirect_valid = 1'b1;
        redirect_sel   = sel;
        branch_target  = bt;
        jalr_target    = jt;
        step();
        redirect_valid = 1'b0;
        redirect_sel   = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] pat;

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_sel   = 2'b00;
        branch_target  = '0;
        jalr_target    = '0;
        repeat (2) step();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_mis", misalign, 0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

        rst_n = 1'b1;
        #1;
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        step();
        chk("addr_4", imem_addr, 32'h4);
        chk("no_valid_yet", out_valid, 0);
        chk("wrap_fffc", imem_addr2, 32'hFFFF_FFFC);
        step();
        chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'hC0DE_0000);
        chk("wrap_0", imem_addr2, 32'h0);
        step();
        chk("pc_4", out_pc, 32'h4);
        step();
        chk("pc_8", out_pc, 32'h8);

        // Backpressure: two entries buffer, fetch stalls, then drains gaplessly.
        out_ready = 1'b0;
        repeat (6) step();
        chk("stall_valid", out_valid, 1);
        chk("stall_pc", out_pc, 32'h8);
        chk("stall_req", imem_req, 0);
        out_ready = 1'b1;
        step();
        chk("drain_12", out_pc, 32'hC);
        step();
        chk("drain_16", out_pc, 32'h10);

        redirect(2'b01, 32'h100, 32'h0);
        chk("br_flush", out_valid, 0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_mis", misalign, 0);
        wait_valid("br_wait");
        chk("br_pc0", out_pc, 32'h100);
        step();
        chk("br_pc1", out_pc, 32'h104);

        redirect(2'b10, 32'h0, 32'h203);
        chk("jalr_addr", imem_addr, 32'h200);
        chk("jalr_mis", misalign, 1);
        step();
        chk("jalr_mis_pulse", misalign, 0);
        redirect(2'b10, 32'h0, 32'h201);
        chk("jalr1_addr", imem_addr, 32'h200);
        chk("jalr1_mis", misalign, 0);

        redirect(2'b01, 32'h102, 32'h0);
        chk("br2_mis", misalign, 1);
        chk("br2_addr", imem_addr, 32'h100);
        wait_valid("br2_wait");
        chk("br2_pc0", out_pc, 32'h100);

        // Ineffective selects leave the stream alone.
        redirect_valid = 1'b1;
        redirect_sel   = 2'b00;
        branch_target  = 32'h900;
        jalr_target    = 32'h900;
        step();
        chk("sel00_pc", out_pc, 32'h104);
        redirect_sel = 2'b11;
        step();
        chk("sel11_pc", out_pc, 32'h108);
        redirect_valid = 1'b0;
        redirect_sel   = 2'b00;
        step();
        chk("after_nop_pc", out_pc, 32'h10C);

        // Back-to-back redirects: the last target wins.
        redirect_valid = 1'b1;
        redirect_sel   = 2'b01;
        branch_target  = 32'h300;
        step();
        redirect_sel = 2'b10;
        jalr_target  = 32'h401;
        step();
        redirect_valid = 1'b0;
        redirect_sel   = 2'b00;
        chk("b2b_addr", imem_addr, 32'h400);
        chk("b2b_flush", out_valid, 0);
        wait_valid("b2b_wait");
        chk("b2b_pc", out_pc, 32'h400);
        chk("b2b_instr", out_instr, 32'hC0DE_0400);

        pat = 16'b1011_0010_1110_0100;
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            if (i == 9) redirect(2'b01, 32'h800, 32'h0);
            else step();
        end
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a live stream.
        wait_valid("pre_rst_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_req", imem_req, 0);
        chk("arst_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 32'h0);
        step();
        step();
        chk("rel_valid", out_valid, 1);
        chk("rel_pc", out_pc, 32'h0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
